// File: rtl/alu_op_encoder_if.sv
// Handshake and decode-result bundle between the decode
// front end, the ALU op encoder and the ALU.
interface alu_op_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_op;
    logic        use_imm;
    logic        br_inv;
    logic        is_branch;
    logic        illegal;
    logic [7:0]  illegal_cnt;

    modport master (
        output in_valid,
        output instr,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  alu_op,
        input  use_imm,
        input  br_inv,
        input  is_branch,
        input  illegal,
        input  illegal_cnt
    );

    modport slave (
        input  in_valid,
        input  instr,
        input  out_ready,
        output in_ready,
        output out_valid,
        output alu_op,
        output use_imm,
        output br_inv,
        output is_branch,
        output illegal,
        output illegal_cnt
    );
endinterface

// File: rtl/alu_op_encoder.sv
// RV32I -> ALU op / operand-select / branch-sense encoder.
// Registered output plus one skid entry, illegal counter.
module alu_op_encoder (
    input  logic            clk,
    input  logic            rst_n,
    alu_op_encoder_if.slave bus
);
    typedef struct packed {
        logic [3:0] alu_op;
        logic       use_imm;
        logic       br_inv;
        logic       is_branch;
        logic       illegal;
    } dec_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    localparam logic [6:0] F7_Z   = 7'b0000000;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    dec_t       dec;
    logic       bad;

    dec_t       out_q, out_d;
    dec_t       skid_q, skid_d;
    logic       ov_q, ov_d;
    logic       sv_q, sv_d;
    logic       rdy_q;
    logic [7:0] cnt_q, cnt_d;
    logic       acc;
    logic       dlv;

    assign opc = bus.instr[6:0];
    assign f3  = bus.instr[14:12];
    assign f7  = bus.instr[31:25];

    // Combinational decode of the incoming word
    always_comb begin
        dec = '0;
        bad = 1'b0;
        case (opc)
            7'b0110011: begin
                if (!(f7 == F7_Z ||
                      (f7 == F7_ALT &&
                       (f3 == 3'b000 || f3 == 3'b101))))
                    bad = 1'b1;
                case (f3)
                    3'b000:  dec.alu_op = f7[5] ? OP_SUB : OP_ADD;
                    3'b001:  dec.alu_op = OP_SLL;
                    3'b010:  dec.alu_op = OP_SLT;
                    3'b011:  dec.alu_op = OP_SLTU;
                    3'b100:  dec.alu_op = OP_XOR;
                    3'b101:  dec.alu_op = f7[5] ? OP_SRA : OP_SRL;
                    3'b110:  dec.alu_op = OP_OR;
                    default: dec.alu_op = OP_AND;
                endcase
            end
            7'b0010011: begin
                dec.use_imm = 1'b1;
                case (f3)
                    3'b000:  dec.alu_op = OP_ADD;
                    3'b001: begin
                        dec.alu_op = OP_SLL;
                        if (f7 != F7_Z) bad = 1'b1;
                    end
                    3'b010:  dec.alu_op = OP_SLT;
                    3'b011:  dec.alu_op = OP_SLTU;
                    3'b100:  dec.alu_op = OP_XOR;
                    3'b101: begin
                        dec.alu_op = f7[5] ? OP_SRA : OP_SRL;
                        if (f7 != F7_Z && f7 != F7_ALT) bad = 1'b1;
                    end
                    3'b110:  dec.alu_op = OP_OR;
                    default: dec.alu_op = OP_AND;
                endcase
            end
            7'b0000011, 7'b0100011, 7'b1100111,
            7'b0110111, 7'b0010111, 7'b1101111: begin
                dec.alu_op  = OP_ADD;
                dec.use_imm = 1'b1;
            end
            7'b1100011: begin
                dec.is_branch = 1'b1;
                case (f3)
                    3'b000: {dec.alu_op, dec.br_inv} = {OP_SUB, 1'b0};
                    3'b001: {dec.alu_op, dec.br_inv} = {OP_SUB, 1'b1};
                    3'b100: {dec.alu_op, dec.br_inv} = {OP_SLT, 1'b1};
                    3'b101: {dec.alu_op, dec.br_inv} = {OP_SLT, 1'b0};
                    3'b110: {dec.alu_op, dec.br_inv} = {OP_SLTU, 1'b1};
                    3'b111: {dec.alu_op, dec.br_inv} = {OP_SLTU, 1'b0};
                    default: bad = 1'b1;
                endcase
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    assign acc = bus.in_valid & rdy_q;
    assign dlv = ov_q & bus.out_ready;

    // Next state for output register, skid entry and counter
    always_comb begin
        out_d  = out_q;
        ov_d   = ov_q;
        skid_d = skid_q;
        sv_d   = sv_q;
        cnt_d  = cnt_q;
        if (!ov_q || dlv) begin
            if (sv_q) begin
                out_d = skid_q;
                ov_d  = 1'b1;
                sv_d  = acc;
                if (acc) skid_d = dec;
            end else begin
                ov_d = acc;
                if (acc) out_d = dec;
            end
        end else if (acc) begin
            skid_d = dec;
            sv_d   = 1'b1;
        end
        if (dlv && out_q.illegal && cnt_q != 8'hFF)
            cnt_d = cnt_q + 8'd1;
    end

    // State registers; in_ready is registered off the skid fill state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            ov_q   <= 1'b0;
            skid_q <= '0;
            sv_q   <= 1'b0;
            rdy_q  <= 1'b0;
            cnt_q  <= 8'd0;
        end else begin
            out_q  <= out_d;
            ov_q   <= ov_d;
            skid_q <= skid_d;
            sv_q   <= sv_d;
            rdy_q  <= !sv_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.in_ready    = rdy_q;
    assign bus.out_valid   = ov_q;
    assign bus.alu_op      = out_q.alu_op;
    assign bus.use_imm     = out_q.use_imm;
    assign bus.br_inv      = out_q.br_inv;
    assign bus.is_branch   = out_q.is_branch;
    assign bus.illegal     = out_q.illegal;
    assign bus.illegal_cnt = cnt_q;
endmodule

// File: tb/tb_alu_op_encoder.sv
// Self-checking bench for alu_op_encoder: vector table,
// randomized traffic against a queue-based reference model.
module tb_alu_op_encoder;
    typedef struct packed {
        logic [3:0] op;
        logic       imm;
        logic       inv;
        logic       br;
        logic       ill;
    } exp_t;

    typedef struct packed {
        logic [31:0] instr;
        exp_t        e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_op_encoder_if bus();

    alu_op_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;
    exp_t q[$];
    int   mcnt = 0;
    vec_t tbl[$];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference decode written from the instruction-set rules
    function automatic exp_t ref_dec(input logic [31:0] w);
        exp_t       e;
        bit         ok;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] amap [8];
        logic [3:0] bop  [8];
        logic       binv [8];
        amap = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
        bop  = '{4'd1, 4'd1, 4'd0, 4'd0, 4'd8, 4'd8, 4'd9, 4'd9};
        binv = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        e   = '0;
        ok  = 1'b1;
        opc = w[6:0];
        f3  = w[14:12];
        f7  = w[31:25];
        case (opc)
            7'h33: begin
                e.op = amap[f3];
                if (f7 == 7'h20 && f3 == 3'd0) e.op = 4'd1;
                else if (f7 == 7'h20 && f3 == 3'd5) e.op = 4'd7;
                else if (f7 != 7'h00) ok = 1'b0;
            end
            7'h13: begin
                e.imm = 1'b1;
                e.op  = amap[f3];
                if (f3 == 3'd1 && f7 != 7'h00) ok = 1'b0;
                if (f3 == 3'd5) begin
                    if (f7 == 7'h20) e.op = 4'd7;
                    else if (f7 != 7'h00) ok = 1'b0;
                end
            end
            7'h03, 7'h23, 7'h67, 7'h37, 7'h17, 7'h6f: e.imm = 1'b1;
            7'h63: begin
                e.br  = 1'b1;
                e.op  = bop[f3];
                e.inv = binv[f3];
                if (f3 == 3'd2 || f3 == 3'd3) ok = 1'b0;
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e     = '0;
            e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic vec_t mk(input logic [31:0] w,
                                input logic [3:0] op,
                                input logic imm, input logic inv,
                                input logic br, input logic ill);
        vec_t v;
        v.instr = w;
        v.e     = '{op: op, imm: imm, inv: inv, br: br, ill: ill};
        return v;
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 11);
        case (k)
            0:  w[6:0] = 7'h33;
            1:  w[6:0] = 7'h13;
            2:  w[6:0] = 7'h03;
            3:  w[6:0] = 7'h23;
            4:  w[6:0] = 7'h67;
            5:  w[6:0] = 7'h37;
            6:  w[6:0] = 7'h17;
            7:  w[6:0] = 7'h6f;
            8:  w[6:0] = 7'h63;
            9:  w[6:0] = 7'h63;
            10: w[6:0] = 7'h33;
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        return w;
    endfunction

    // Scoreboard: words in flight, delivery order, in_ready and counter
    always @(negedge clk) begin
        if (mon_en) begin
            chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
            chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
            if (bus.out_valid && q.size() != 0)
                chk("fields",
                    32'({bus.alu_op, bus.use_imm, bus.br_inv,
                         bus.is_branch, bus.illegal}),
                    32'(q[0]));
            chk("illegal_cnt", 32'(bus.illegal_cnt), 32'(mcnt));
            if (bus.out_valid && bus.out_ready && q.size() != 0) begin
                if (q[0].ill && mcnt < 255) mcnt++;
                void'(q.pop_front());
            end
            if (bus.in_valid && bus.in_ready)
                q.push_back(ref_dec(bus.instr));
        end
    end

    task automatic push(input logic [31:0] w);
        logic r;
        bit   done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.instr    = w;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            r = bus.in_ready;
            @(posedge clk);
            #1;
            if (r) done = 1'b1;
        end
        if (!done) begin
            failures++;
            $display("FAIL push_timeout actual=stuck required=accept");
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b1;
        bus.instr     = 32'h00B50533;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;

        tbl.push_back(mk(32'h40B50533, 4'd1, 0, 0, 0, 0));
        tbl.push_back(mk(32'h40B55533, 4'd7, 0, 0, 0, 0));
        tbl.push_back(mk(32'h00B56533, 4'd3, 0, 0, 0, 0));
        tbl.push_back(mk(32'h4055D513, 4'd7, 1, 0, 0, 0));
        tbl.push_back(mk(32'h00052503, 4'd0, 1, 0, 0, 0));
        tbl.push_back(mk(32'h000012B7, 4'd0, 1, 0, 0, 0));
        tbl.push_back(mk(32'h00B51463, 4'd1, 0, 1, 1, 0));
        tbl.push_back(mk(32'h00B57463, 4'd9, 0, 0, 1, 0));
        tbl.push_back(mk(32'h00B52463, 4'd0, 0, 0, 0, 1));
        tbl.push_back(mk(32'h00B50533, 4'd0, 0, 0, 0, 0));
        tbl.push_back(mk(32'h02B50533, 4'd0, 0, 0, 0, 1));
        tbl.push_back(mk(32'h00B57533, 4'd2, 0, 0, 0, 0));
        tbl.push_back(mk(32'h00B54463, 4'd8, 0, 1, 1, 0));
        tbl.push_back(mk(32'hFFFFFFFF, 4'd0, 0, 0, 0, 1));
        tbl.push_back(mk(32'h4055C513, 4'd4, 1, 0, 0, 0));
        tbl.push_back(mk(32'h40051513, 4'd0, 0, 0, 0, 1));
        tbl.push_back(mk(32'h40050513, 4'd0, 1, 0, 0, 0));
        tbl.push_back(mk(32'h00B53533, 4'd9, 0, 0, 0, 0));
        tbl.push_back(mk(32'h00B52533, 4'd8, 0, 0, 0, 0));
        tbl.push_back(mk(32'h40B51533, 4'd0, 0, 0, 0, 1));

        // reset held with in_valid asserted
        repeat (3) begin
            @(negedge clk);
            chk("rst_in_ready", 32'(bus.in_ready), 0);
            chk("rst_out_valid", 32'(bus.out_valid), 0);
            chk("rst_cnt", 32'(bus.illegal_cnt), 0);
            chk("rst_fields",
                32'({bus.alu_op, bus.use_imm, bus.br_inv,
                     bus.is_branch, bus.illegal}), 0);
        end
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rel_in_ready_pre", 32'(bus.in_ready), 0);
        @(negedge clk);
        chk("rel_in_ready_post", 32'(bus.in_ready), 1);
        mon_en = 1'b1;

        // table vectors streamed back to back
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.instr    = tbl[0].instr;
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            if (i + 1 < tbl.size()) bus.instr = tbl[i + 1].instr;
            else bus.in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), 32'(bus.out_valid), 1);
            chk($sformatf("tbl%0d_fields", i),
                32'({bus.alu_op, bus.use_imm, bus.br_inv,
                     bus.is_branch, bus.illegal}),
                32'(tbl[i].e));
        end
        repeat (3) @(posedge clk);
        #1;

        // backpressure: two held, third waits for drain
        bus.out_ready = 1'b0;
        push(32'h40B50533);
        push(32'h00B56533);
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(bus.in_ready), 0);
            chk("bp_out_valid", 32'(bus.out_valid), 1);
            chk("bp_stable_op", 32'(bus.alu_op), 1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        push(32'h00B57463);
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_drained", 32'(bus.out_valid), 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.instr     = rnd_instr();
            bus.out_ready = ($urandom_range(0, 2) != 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // counter saturation
        bus.in_valid = 1'b1;
        bus.instr    = 32'hFFFFFFFF;
        repeat (300 + 255) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("cnt_sat", 32'(bus.illegal_cnt), 255);

        // reset while stalled with both entries full
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        push(32'hFFFFFFFF);
        push(32'h00B50533);
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("mid_rst_cnt", 32'(bus.illegal_cnt), 0);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 0);
        q.delete();
        mcnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 1);
        chk("post_rst_out_valid", 32'(bus.out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
